// File: rtl/rom_stream_reader.sv
// ROM read sequencer: issues addresses to a 1-cycle-latency ROM and streams words over valid/ready.
// Optional transfer checksum enabled by defining ROM_STREAM_READER_CHECKSUM_EN.
module rom_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  rd_pend1_q, rd_pend1_d;
  logic                  rd_pend2_q, rd_pend2_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            count_q, count_d;
  logic                  done_q, done_d;

  logic                  m_valid_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  credit_s;
  logic                  issue_s;

`ifdef ROM_STREAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  start_accept_s;
`endif

  // Next-state logic: FSM, issue credit, read pipeline and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    rom_addr_d  = rom_addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    done_d      = 1'b0;

    m_valid_s = (count_q != 3'd0);
    pop_s     = m_valid_s && m_ready_i;
    push_s    = rd_pend2_q;
    // Two read stages in flight plus stored words must fit the FIFO.
    credit_s  = (({1'b0, count_q} + {3'b000, rd_pend1_q} + {3'b000, rd_pend2_q}) < 4'd4);
    issue_s   = (state_q == ST_ISSUE) && credit_s;

    if (pop_s) begin
      beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
      rd_ptr_d   = rd_ptr_q + 2'd1;
    end else begin
      beat_cnt_d = beat_cnt_q;
      rd_ptr_d   = rd_ptr_q;
    end

    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = rom_data_i;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != {LEN_WIDTH{1'b0}}) begin
            state_d     = ST_ISSUE;
            next_addr_d = base_addr_i;
            issue_cnt_d = len_i;
            beat_cnt_d  = len_i;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_s) begin
          rom_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + ADDR_WIDTH'(1);
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
          if (issue_cnt_q == LEN_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (pop_s && (beat_cnt_q == LEN_WIDTH'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_pend1_d = issue_s;
    rd_pend2_d = rd_pend1_q;
  end

`ifdef ROM_STREAM_READER_CHECKSUM_EN
  // Checksum accumulator: cleared on start accept, summed over transferred beats.
  always_comb begin
    start_accept_s = (state_q == ST_IDLE) && start_i;
    if (start_accept_s) begin
      csum_d = {DATA_WIDTH{1'b0}};
    end else if (pop_s) begin
      csum_d = csum_q + m_data_o;
    end else begin
      csum_d = csum_q;
    end
  end
`endif

  // State registers with synchronous reset; reset also discards in-flight reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      next_addr_q <= {ADDR_WIDTH{1'b0}};
      rom_addr_q  <= {ADDR_WIDTH{1'b0}};
      issue_cnt_q <= {LEN_WIDTH{1'b0}};
      beat_cnt_q  <= {LEN_WIDTH{1'b0}};
      rd_pend1_q  <= 1'b0;
      rd_pend2_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      done_q      <= 1'b0;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
      csum_q      <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      rom_addr_q  <= rom_addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_pend1_q  <= rd_pend1_d;
      rd_pend2_q  <= rd_pend2_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign rom_addr_o = rom_addr_q;
  assign m_valid_o  = m_valid_s;
  assign m_data_o   = fifo_mem_q[rd_ptr_q];
  assign m_last_o   = m_valid_s && (beat_cnt_q == LEN_WIDTH'(1));

`ifdef ROM_STREAM_READER_CHECKSUM_EN
  assign checksum_o = csum_q;
`else
  assign checksum_o = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed self-checking bench for rom_stream_reader with a behavioural 1-cycle ROM (mem[i]=i).
module tb_rom_stream_reader;

  logic       clk;
  logic       rst_i;
  logic       start_i;
  logic [7:0] base_addr_i;
  logic [8:0] len_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] rom_addr_o;
  logic [7:0] rom_data;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_last_o;
  logic       m_ready_i;
  logic [7:0] checksum_o;

  logic [7:0] rom_mem [256];

  int checks = 0;
  int errors = 0;

  rom_stream_reader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready_i),
    .checksum_o  (checksum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom_mem[rom_addr_o];

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer at a negedge and follows it until done_o, checking every beat.
  // mode: 0 ready always, 1 ready toggles, 2 ready low for a window.
  task automatic run_xfer(input logic [7:0] base, input int len, input int mode,
                          input int stall_start, input int stall_cycles, input bit chk_lat,
                          input int restart_at, input bit chk_busy);
    int c, beats, first_c, last_c;
    bit done_seen, stalled, busy_bad, r;
    logic [7:0] held_d, exp_d, ea, sum;
    logic held_l;
    beats = 0; first_c = -1; last_c = -1; c = 0;
    done_seen = 1'b0; stalled = 1'b0; busy_bad = 1'b0; r = 1'b1;
    held_d = 8'h00; held_l = 1'b0; sum = 8'h00;
    start_i = 1'b1; base_addr_i = base; len_i = 9'(len); m_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (!done_seen && c < len * 3 + 60) begin
      if (chk_lat && c >= 1 && c <= 3) begin
        ea = base + 8'(c - 1);
        chk("rom_addr_issue", 32'(rom_addr_o), 32'(ea));
      end
      if (m_valid_o === 1'b1 && first_c < 0) first_c = c;
      if (stalled) begin
        chk("stall_valid", 32'(m_valid_o), 32'd1);
        chk("stall_data", 32'(m_data_o), 32'(held_d));
        chk("stall_last", 32'(m_last_o), 32'(held_l));
      end
      if (done_o === 1'b1) begin
        done_seen = 1'b1;
      end else begin
        if (busy_o !== 1'b1) busy_bad = 1'b1;
        case (mode)
          0:       r = 1'b1;
          1:       r = (c % 2 == 0);
          2:       r = !(c >= stall_start && c < stall_start + stall_cycles);
          default: r = 1'b1;
        endcase
        m_ready_i   = r;
        start_i     = (c == restart_at);
        base_addr_i = 8'h55;
        len_i       = 9'd3;
        if (m_valid_o === 1'b1 && r) begin
          exp_d = base + 8'(beats);
          chk("beat_data", 32'(m_data_o), 32'(exp_d));
          chk("beat_last", 32'(m_last_o), 32'(beats == len - 1));
          sum    = sum + exp_d;
          last_c = c;
          beats++;
        end
        stalled = (m_valid_o === 1'b1) && !r;
        held_d  = m_data_o;
        held_l  = m_last_o;
        @(negedge clk);
        c++;
      end
    end
    start_i = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("beat_count", 32'(beats), 32'(len));
    chk("done_busy_low", 32'(busy_o), 32'd0);
    chk("done_valid_low", 32'(m_valid_o), 32'd0);
    ea = base + 8'(len - 1);
    chk("rom_addr_hold", 32'(rom_addr_o), 32'(ea));
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    chk("checksum", 32'(checksum_o), 32'(sum));
`else
    chk("checksum", 32'(checksum_o), 32'd0);
`endif
    if (chk_lat) begin
      chk("first_valid_latency", 32'(first_c), 32'd3);
      chk("consecutive_beats", 32'(last_c - first_c), 32'(len - 1));
    end
    if (chk_busy) chk("busy_throughout", 32'(busy_bad), 32'd0);
    @(negedge clk);
    chk("done_single_pulse", 32'(done_o), 32'd0);
    m_ready_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = 8'h00; len_i = 9'd0; m_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr_o), 32'd0);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_last", 32'(m_last_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk("rst_checksum", 32'(checksum_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Basic stream, wrap-around, toggling backpressure, full depth with a long stall.
    run_xfer(8'h00, 4, 0, 0, 0, 1'b1, -1, 1'b1);
    run_xfer(8'hFE, 4, 0, 0, 0, 1'b1, -1, 1'b1);
    run_xfer(8'h30, 8, 1, 0, 0, 1'b0, -1, 1'b1);
    run_xfer(8'h00, 256, 2, 100, 20, 1'b0, -1, 1'b1);

    // Zero-length command.
    start_i = 1'b1; base_addr_i = 8'h40; len_i = 9'd0;
    @(negedge clk);
    start_i = 1'b0;
    chk("len0_done", 32'(done_o), 32'd1);
    chk("len0_busy", 32'(busy_o), 32'd0);
    chk("len0_valid", 32'(m_valid_o), 32'd0);
    @(negedge clk);
    chk("len0_done_clear", 32'(done_o), 32'd0);
    chk("len0_busy_after", 32'(busy_o), 32'd0);
    chk("len0_valid_after", 32'(m_valid_o), 32'd0);

    // Start pulsed while busy must not disturb the running transfer.
    run_xfer(8'h20, 6, 0, 0, 0, 1'b0, 2, 1'b1);

    // Reset two cycles into a transfer.
    start_i = 1'b1; base_addr_i = 8'h00; len_i = 9'd16;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_valid", 32'(m_valid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr_o), 32'd0);
    chk("midrst_checksum", 32'(checksum_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(m_valid_o), 32'd0);
      chk("midrst_no_done", 32'(done_o), 32'd0);
    end
    run_xfer(8'h10, 2, 0, 0, 0, 1'b0, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
